// File: rtl/velocimetro_pkg.sv
// Shared definitions for the velocimetro datapath: preset wheel circumferences,
// default clamp limits, the auto-repeat state enum and saturating helpers.
`timescale 1ns/1ps
package velocimetro_pkg;

  localparam int MIN_CIRC_DEF = 1000;
  localparam int MAX_CIRC_DEF = 3000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  // Entries beyond the four standard wheels stay inside the default clamp range.
  function automatic logic [15:0] preset_mm(input logic [3:0] idx);
    case (idx)
      4'd0:    preset_mm = 16'd2326;
      4'd1:    preset_mm = 16'd2096;
      4'd2:    preset_mm = 16'd2155;
      4'd3:    preset_mm = 16'd2200;
      4'd4:    preset_mm = 16'd2050;
      4'd5:    preset_mm = 16'd2100;
      4'd6:    preset_mm = 16'd2250;
      4'd7:    preset_mm = 16'd2300;
      default: preset_mm = 16'd2326;
    endcase
  endfunction

  function automatic logic [31:0] sat_step(input logic [31:0] cur, input logic up,
                                           input logic [31:0] lo, input logic [31:0] hi);
    logic [32:0] sum;
    sum = {1'b0, cur} + 33'd1;
    if (up) sat_step = (sum > {1'b0, hi}) ? hi : sum[31:0];
    else    sat_step = (cur <= lo) ? lo : cur - 32'd1;
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (val < lo)      clamp = lo;
    else if (val > hi) clamp = hi;
    else               clamp = val;
  endfunction

endpackage

// File: rtl/pulsador_repetir.sv
// Hold-to-auto-repeat timing FSM: one step on press, another after HOLD_CYCLES,
// then one every REPEAT_CYCLES until release, abort or direction change.
`timescale 1ns/1ps
module pulsador_repetir
  import velocimetro_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic lvl,
  input  logic dir,
  output logic step
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  rep_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Released, both pressed (lvl low), external clear, or a reversal all end the press.
  assign abort = clr | ~lvl | (dir != dir_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lvl && !clr) begin
          step    = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = '0;
          dir_d   = dir;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          step    = 1'b1;
          state_d = ST_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
          step  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/circunferencia_ajustable.sv
// Adjustable wheel circumference register: preset select, saturating up/down with
// auto-repeat, and clamped direct load. Define CIRC_LOCK_EN to add the lock input.
`timescale 1ns/1ps
module circunferencia_ajustable
  import velocimetro_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NUM_PRESETS   = 4,
  parameter int DEFAULT_IDX   = 0,
  parameter int MIN_CIRC      = MIN_CIRC_DEF,
  parameter int MAX_CIRC      = MAX_CIRC_DEF,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           btn_sel,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           load_valid,
  input  logic [WIDTH-1:0]               load_data,
`ifdef CIRC_LOCK_EN
  input  logic                           lock,
`endif
  output logic                           load_ready,
  output logic [WIDTH-1:0]               circunferencia,
  output logic [$clog2(NUM_PRESETS)-1:0] preset_idx,
  output logic                           changed
);

  localparam int IDX_W = $clog2(NUM_PRESETS);

  logic [WIDTH-1:0] circ_q, circ_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sel_q;
  logic             changed_q;
  logic             lock_act;
  logic             blk_act;
  logic             sel_rise, load_fire, lvl, rep_clr, step_p;

`ifdef CIRC_LOCK_EN
  // Blocks the repeater after unlock until every direction button has been released.
  logic blk_q, blk_d;
  assign lock_act = lock;
  assign blk_d    = lock | (blk_q & (btn_up | btn_down));
  assign blk_act  = blk_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_q <= 1'b0;
    else        blk_q <= blk_d;
  end
`else
  assign lock_act = 1'b0;
  assign blk_act  = 1'b0;
`endif

  assign sel_rise   = btn_sel & ~sel_q;
  assign load_fire  = load_valid & ~lock_act;
  assign load_ready = load_fire;
  assign lvl        = btn_up ^ btn_down;
  assign rep_clr    = load_fire | lock_act | blk_act;

  pulsador_repetir #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_rep (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (rep_clr),
    .lvl  (lvl),
    .dir  (btn_up),
    .step (step_p)
  );

  always_comb begin
    circ_d = circ_q;
    idx_d  = idx_q;
    if (load_fire) begin
      circ_d = WIDTH'(clamp(32'(load_data), 32'(MIN_CIRC), 32'(MAX_CIRC)));
    end else if (sel_rise && !lock_act) begin
      idx_d  = (idx_q == IDX_W'(NUM_PRESETS - 1)) ? '0 : idx_q + IDX_W'(1);
      circ_d = WIDTH'(preset_mm(4'(idx_d)));
    end else if (step_p) begin
      circ_d = WIDTH'(sat_step(32'(circ_q), btn_up, 32'(MIN_CIRC), 32'(MAX_CIRC)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      circ_q    <= WIDTH'(preset_mm(4'(DEFAULT_IDX)));
      idx_q     <= IDX_W'(DEFAULT_IDX);
      sel_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      circ_q    <= circ_d;
      idx_q     <= idx_d;
      sel_q     <= btn_sel;
      changed_q <= (circ_d != circ_q);
    end
  end

  assign circunferencia = circ_q;
  assign preset_idx     = idx_q;
  assign changed        = changed_q;

endmodule

// File: tb/tb_circunferencia_ajustable.sv
// Scoreboard bench for circunferencia_ajustable: stimulus pushes expected
// (value, index, cycle) on each change; a negedge monitor pops on every changed pulse.
`timescale 1ns/1ps
module tb_circunferencia_ajustable;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             btn_sel, btn_up, btn_down, load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready, changed;
  logic [WIDTH-1:0] circunferencia;
  logic [1:0]       preset_idx;
`ifdef CIRC_LOCK_EN
  logic             lock;
`endif

  circunferencia_ajustable #(
    .WIDTH(WIDTH), .NUM_PRESETS(4), .DEFAULT_IDX(0), .MIN_CIRC(1000), .MAX_CIRC(3000),
    .HOLD_CYCLES(10), .REPEAT_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_sel       (btn_sel),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .load_valid    (load_valid),
    .load_data     (load_data),
`ifdef CIRC_LOCK_EN
    .lock          (lock),
`endif
    .load_ready    (load_ready),
    .circunferencia(circunferencia),
    .preset_idx    (preset_idx),
    .changed       (changed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int circ; int idx; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Expected change visible after the next active edge plus off further cycles.
  task automatic push(input int c, input int i, input int off);
    exp_t e;
    e.circ = c; e.idx = i; e.cyc = cyc + 1 + off;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_changed_pulse", int'(circunferencia), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("change_value", int'(circunferencia), e.circ);
        check("change_idx", int'(preset_idx), e.idx);
        check("change_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; btn_sel = 0; btn_up = 0; btn_down = 0; load_valid = 0; load_data = '0;
`ifdef CIRC_LOCK_EN
    lock = 1'b0;
`endif
    // Reset state
    tick(3);
    @(negedge clk);
    check("reset_circ", int'(circunferencia), 2326);
    check("reset_idx", int'(preset_idx), 0);
    check("reset_changed", int'(changed), 0);
    check("reset_load_ready", int'(load_ready), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    @(negedge clk);
    check("post_reset_circ", int'(circunferencia), 2326);
    check("post_reset_changed", int'(changed), 0);

    // Preset cycling with wrap
    tick(1);
    begin
      int pv [4] = '{2096, 2155, 2200, 2326};
      for (int k = 0; k < 4; k++) begin
        btn_sel = 1'b1; push(pv[k], (k + 1) % 4, 0);
        tick(1); btn_sel = 1'b0;
        tick(2);
      end
    end
    check("sel_queue_drained", exp_q.size(), 0);

    // Auto-repeat: steps at offsets 0,10,14,18,22 over 25 held cycles
    btn_up = 1'b1;
    push(2327, 0, 0); push(2328, 0, 10); push(2329, 0, 14); push(2330, 0, 18); push(2331, 0, 22);
    tick(25);
    btn_up = 1'b0;
    tick(12);
    @(negedge clk);
    check("repeat_final", int'(circunferencia), 2331);
    check("repeat_queue_drained", exp_q.size(), 0);

    // Load clamped high, saturating up, load clamped low
    tick(1);
    load_valid = 1'b1; load_data = 16'd3500; push(3000, 0, 0);
    @(negedge clk);
    check("load_ready_high", int'(load_ready), 1);
    tick(1); load_valid = 1'b0;
    tick(1); btn_up = 1'b1;
    tick(3); btn_up = 1'b0;
    tick(2);
    @(negedge clk);
    check("sat_max_hold", int'(circunferencia), 3000);
    tick(1);
    load_valid = 1'b1; load_data = 16'd500; push(1000, 0, 0);
    tick(1); load_valid = 1'b0;
    tick(2);

    // Load wins over select and step in the same cycle
    load_valid = 1'b1; load_data = 16'd2500; btn_sel = 1'b1; btn_up = 1'b1; push(2500, 0, 0);
    tick(1); load_valid = 1'b0; btn_sel = 1'b0; btn_up = 1'b0;
    tick(12);
    @(negedge clk);
    check("prio_value", int'(circunferencia), 2500);
    check("prio_idx", int'(preset_idx), 0);
    tick(1);
    btn_up = 1'b1; push(2501, 0, 0);
    tick(1); btn_up = 1'b0;
    tick(2);
    btn_sel = 1'b1; push(2096, 1, 0);
    tick(1); btn_sel = 1'b0;
    tick(2);

    // Down saturation at MIN, single down step, both buttons
    load_valid = 1'b1; load_data = 16'd1000; push(1000, 1, 0);
    tick(1); load_valid = 1'b0;
    tick(1); btn_down = 1'b1;
    tick(1); btn_down = 1'b0;
    tick(3);
    @(negedge clk);
    check("sat_min_hold", int'(circunferencia), 1000);
    tick(1);
    load_valid = 1'b1; load_data = 16'd1500; push(1500, 1, 0);
    tick(1); load_valid = 1'b0;
    tick(1); btn_down = 1'b1; push(1499, 1, 0);
    tick(1); btn_down = 1'b0;
    tick(2);
    btn_up = 1'b1; btn_down = 1'b1;
    tick(15); btn_up = 1'b0; btn_down = 1'b0;
    tick(2);
    @(negedge clk);
    check("both_buttons_no_step", int'(circunferencia), 1499);

`ifdef CIRC_LOCK_EN
    tick(1);
    lock = 1'b1; btn_sel = 1'b1; btn_up = 1'b1; load_valid = 1'b1; load_data = 16'd2000;
    @(negedge clk);
    check("lock_load_ready", int'(load_ready), 0);
    tick(5); btn_sel = 1'b0; load_valid = 1'b0;
    tick(1); lock = 1'b0;
    tick(15);
    @(negedge clk);
    check("lock_frozen", int'(circunferencia), 1499);
    check("lock_idx", int'(preset_idx), 1);
    tick(1); btn_up = 1'b0;
    tick(2); btn_up = 1'b1; push(1500, 1, 0);
    tick(1); btn_up = 1'b0;
    tick(2);
`endif

    tick(5);
    check("final_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
